// File: rtl/mem_stage_lsu.sv
// Load/store unit for the memory pipeline stage: a single outstanding request, optional
// splitting of word-crossing accesses into two bus beats, and load alignment/extension.
module mem_stage_lsu #(
   parameter int XLEN             = 32,
   parameter int SPLIT_MISALIGNED = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [6:0]          req_opcode,
   input  logic [2:0]          req_funct3,
   input  logic [XLEN-1:0]     req_addr,
   input  logic [XLEN-1:0]     req_wdata,
   output logic                mem_valid,
   input  logic                mem_ready,
   output logic [XLEN-1:0]     mem_addr,
   output logic [XLEN/8-1:0]   mem_we,
   output logic [XLEN-1:0]     mem_wdata,
   input  logic                mem_rvalid,
   input  logic [XLEN-1:0]     mem_rdata,
   output logic                rsp_valid,
   output logic [XLEN-1:0]     rsp_data,
   output logic                rsp_fault
);

   localparam int unsigned NB = XLEN / 8;
   localparam int unsigned OW = $clog2(NB);
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;

   typedef enum logic [2:0] {IDLE, ISSUE0, WAIT0, ISSUE1, WAIT1, RESP} state_t;
   state_t state, state_next;

   // Request decode, evaluated on the live request inputs.
   logic                 is_load_in, is_store_in, bad_in, misalign_in, cross_in;
   int unsigned          size_in, off_in;
   logic [2*NB-1:0]      mask_in;
   logic [2*XLEN-1:0]    data_in;
   logic [XLEN-1:0]      base_in;

   // Latched request.
   logic                 is_load_q, cross_q;
   logic [2:0]           f3_q;
   logic [OW-1:0]        off_q;
   logic [XLEN-1:0]      base_q, lo_q;
   logic [2*NB-1:0]      mask_q;
   logic [2*XLEN-1:0]    data_q;
   logic [XLEN-1:0]      rsp_data_q;
   logic                 rsp_fault_q;

   // Load alignment.
   logic [2*XLEN-1:0]    rd_pair;
   logic [XLEN-1:0]      rd_shift, rd_mask, load_result;
   int unsigned          bits;

   logic                 accept, capture_lo, rsp_set, rsp_fault_next;
   logic [XLEN-1:0]      rsp_data_next;

   always_comb begin
      is_load_in  = (req_opcode == OP_LOAD);
      is_store_in = (req_opcode == OP_STORE);
      size_in     = 32'd1 << req_funct3[1:0];
      off_in      = 32'(req_addr[OW-1:0]);
      bad_in      = (is_load_in && req_funct3 == 3'b111)
                 || (is_store_in && req_funct3[2])
                 || ((XLEN == 32) && (req_funct3 == 3'b011 || req_funct3 == 3'b110));
      misalign_in = (32'(req_addr[3:0]) & (size_in - 32'd1)) != 32'd0;
      cross_in    = (off_in + size_in) > NB;
      mask_in     = is_load_in ? '0 : (2*NB)'(((64'd1 << size_in) - 64'd1) << off_in);
      data_in     = is_load_in ? '0 : ((2*XLEN)'(req_wdata) << (8 * off_in));
      base_in     = req_addr & ~(XLEN'(NB - 1));
   end

   // The high word is only meaningful once the first beat's data sits in lo_q.
   always_comb begin
      rd_pair     = (state == WAIT1) ? {mem_rdata, lo_q} : {{XLEN{1'b0}}, mem_rdata};
      rd_shift    = XLEN'(rd_pair >> (8 * 32'(off_q)));
      bits        = 32'd8 << f3_q[1:0];
      rd_mask     = (bits >= XLEN) ? '1 : ((XLEN'(1) << bits) - XLEN'(1));
      load_result = rd_shift & rd_mask;
      if (!f3_q[2] && (|(rd_shift & (rd_mask ^ (rd_mask >> 1)))))
         load_result = load_result | ~rd_mask;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next     = state;
      accept         = 1'b0;
      capture_lo     = 1'b0;
      rsp_set        = 1'b0;
      rsp_fault_next = 1'b0;
      rsp_data_next  = '0;
      req_ready      = (state == IDLE);
      mem_valid      = 1'b0;
      mem_addr       = '0;
      mem_we         = '0;
      mem_wdata      = '0;
      rsp_valid      = (state == RESP);

      unique case (state)
         IDLE: begin
            if (req_valid) begin
               accept = 1'b1;
               if (!is_load_in && !is_store_in) begin
                  state_next = RESP;
                  rsp_set    = 1'b1;
               end else if (bad_in || (misalign_in && SPLIT_MISALIGNED == 0)) begin
                  state_next     = RESP;
                  rsp_set        = 1'b1;
                  rsp_fault_next = 1'b1;
               end else begin
                  state_next = ISSUE0;
               end
            end
         end
         ISSUE0: begin
            mem_valid = 1'b1;
            mem_addr  = base_q;
            mem_we    = mask_q[NB-1:0];
            mem_wdata = data_q[XLEN-1:0];
            if (mem_ready) begin
               if (is_load_q)    state_next = WAIT0;
               else if (cross_q) state_next = ISSUE1;
               else begin
                  state_next = RESP;
                  rsp_set    = 1'b1;
               end
            end
         end
         WAIT0: begin
            if (mem_rvalid) begin
               if (cross_q) begin
                  state_next = ISSUE1;
                  capture_lo = 1'b1;
               end else begin
                  state_next    = RESP;
                  rsp_set       = 1'b1;
                  rsp_data_next = load_result;
               end
            end
         end
         ISSUE1: begin
            mem_valid = 1'b1;
            mem_addr  = base_q + XLEN'(NB);
            mem_we    = mask_q[2*NB-1:NB];
            mem_wdata = data_q[2*XLEN-1:XLEN];
            if (mem_ready) begin
               if (is_load_q) state_next = WAIT1;
               else begin
                  state_next = RESP;
                  rsp_set    = 1'b1;
               end
            end
         end
         WAIT1: begin
            if (mem_rvalid) begin
               state_next    = RESP;
               rsp_set       = 1'b1;
               rsp_data_next = load_result;
            end
         end
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         is_load_q   <= 1'b0;
         cross_q     <= 1'b0;
         f3_q        <= '0;
         off_q       <= '0;
         base_q      <= '0;
         mask_q      <= '0;
         data_q      <= '0;
         lo_q        <= '0;
         rsp_data_q  <= '0;
         rsp_fault_q <= 1'b0;
      end else begin
         if (accept) begin
            is_load_q <= is_load_in;
            cross_q   <= cross_in;
            f3_q      <= req_funct3;
            off_q     <= req_addr[OW-1:0];
            base_q    <= base_in;
            mask_q    <= mask_in;
            data_q    <= data_in;
         end
         if (capture_lo) lo_q <= mem_rdata;
         if (rsp_set) begin
            rsp_data_q  <= rsp_data_next;
            rsp_fault_q <= rsp_fault_next;
         end
      end
   end

   assign rsp_data  = rsp_data_q;
   assign rsp_fault = rsp_fault_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: a vector table of single transactions plus
// hand-written backpressure, SPLIT_MISALIGNED=0 and mid-operation reset sequences.
module tb_mem_stage_lsu;

   localparam logic [6:0] OP_L = 7'b0000011;
   localparam logic [6:0] OP_S = 7'b0100011;
   localparam logic [6:0] OP_N = 7'b0110011;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0, req_valid0 = 1'b0;
   logic [6:0]  req_opcode = '0;
   logic [2:0]  req_funct3 = '0;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic        mem_ready = 1'b0, mem_rvalid = 1'b0;
   logic [31:0] mem_rdata = '0;

   logic        req_ready, mem_valid, rsp_valid, rsp_fault;
   logic [31:0] mem_addr, mem_wdata, rsp_data;
   logic [3:0]  mem_we;
   logic        req_ready0, mem_valid0, rsp_valid0, rsp_fault0;
   logic [31:0] mem_addr0, mem_wdata0, rsp_data0;
   logic [3:0]  mem_we0;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   mem_stage_lsu #(.XLEN(32), .SPLIT_MISALIGNED(1)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_opcode(req_opcode), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_we(mem_we),
      .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_fault(rsp_fault));

   mem_stage_lsu #(.XLEN(32), .SPLIT_MISALIGNED(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid0), .req_ready(req_ready0),
      .req_opcode(req_opcode), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .mem_valid(mem_valid0), .mem_ready(mem_ready), .mem_addr(mem_addr0), .mem_we(mem_we0),
      .mem_wdata(mem_wdata0), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .rsp_valid(rsp_valid0), .rsp_data(rsp_data0), .rsp_fault(rsp_fault0));

   typedef struct {
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rlo;
      logic [31:0] rhi;
      int          nbeats;
      logic [31:0] a0;
      logic [3:0]  w0;
      logic [31:0] d0;
      logic [31:0] a1;
      logic [3:0]  w1;
      logic [31:0] d1;
      logic [31:0] rdata;
      logic        fault;
      int          lat;
   } vec_t;

   vec_t vecs [16];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      logic [31:0] ba [2];
      logic [3:0]  bw [2];
      logic [31:0] bd [2];
      int          nb = 0;
      int          cyc = 0;
      logic        pend = 1'b0;
      logic        done = 1'b0;
      logic [31:0] pdata = '0;
      logic [31:0] rd = '0;
      logic        rf = 1'b0;
      req_opcode = v.op;
      req_funct3 = v.f3;
      req_addr   = v.addr;
      req_wdata  = v.wdata;
      req_valid  = 1'b1;
      mem_ready  = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      cyc = 1;
      while (!done && cyc < 20) begin
         @(negedge clk);
         if (mem_valid) begin
            if (nb < 2) begin
               ba[nb] = mem_addr;
               bw[nb] = mem_we;
               bd[nb] = mem_wdata;
            end
            if (mem_we == 4'b0000) begin
               pend  = 1'b1;
               pdata = (nb == 0) ? v.rlo : v.rhi;
            end
            nb++;
         end
         if (rsp_valid) begin
            done = 1'b1;
            rd   = rsp_data;
            rf   = rsp_fault;
         end else begin
            @(posedge clk); #1;
            mem_rvalid = pend;
            mem_rdata  = pend ? pdata : 32'hDEADBEEF;
            pend = 1'b0;
            cyc++;
         end
      end
      chk($sformatf("v%0d_rsp_seen", idx), 64'(done), 64'(1));
      if (done) begin
         chk($sformatf("v%0d_latency", idx), 64'(cyc), 64'(v.lat));
         chk($sformatf("v%0d_rsp_data", idx), 64'(rd), 64'(v.rdata));
         chk($sformatf("v%0d_rsp_fault", idx), 64'(rf), 64'(v.fault));
      end
      chk($sformatf("v%0d_beats", idx), 64'(nb), 64'(v.nbeats));
      if (nb >= 1 && v.nbeats >= 1) begin
         chk($sformatf("v%0d_addr0", idx), 64'(ba[0]), 64'(v.a0));
         chk($sformatf("v%0d_we0", idx), 64'(bw[0]), 64'(v.w0));
         chk($sformatf("v%0d_wdata0", idx), 64'(bd[0]), 64'(v.d0));
      end
      if (nb >= 2 && v.nbeats >= 2) begin
         chk($sformatf("v%0d_addr1", idx), 64'(ba[1]), 64'(v.a1));
         chk($sformatf("v%0d_we1", idx), 64'(bw[1]), 64'(v.w1));
         chk($sformatf("v%0d_wdata1", idx), 64'(bd[1]), 64'(v.d1));
      end
      @(posedge clk); #1;
      mem_rvalid = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d_rsp_one_cycle", idx), 64'(rsp_valid), 64'(0));
      chk($sformatf("v%0d_rsp_data_hold", idx), 64'(rsp_data), 64'(v.rdata));
      chk($sformatf("v%0d_idle_ready", idx), 64'(req_ready), 64'(1));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      //         op    f3      addr          wdata         rlo           rhi           nb a0            w0       d0            a1            w1       d1            rdata         flt   lat
      vecs[0]  = '{OP_S, 3'b000, 32'h00001003, 32'h000000A5, 32'h0,        32'h0,        1, 32'h00001000, 4'b1000, 32'hA5000000, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b0, 2};
      vecs[1]  = '{OP_S, 3'b010, 32'h00002002, 32'h11223344, 32'h0,        32'h0,        2, 32'h00002000, 4'b1100, 32'h33440000, 32'h00002004, 4'b0011, 32'h00001122, 32'h0,        1'b0, 3};
      vecs[2]  = '{OP_L, 3'b001, 32'h00003003, 32'h0,        32'hAB000000, 32'h000000F0, 2, 32'h00003000, 4'b0000, 32'h0,        32'h00003004, 4'b0000, 32'h0,        32'hFFFFF0AB, 1'b0, 5};
      vecs[3]  = '{OP_L, 3'b101, 32'h00003003, 32'h0,        32'hAB000000, 32'h000000F0, 2, 32'h00003000, 4'b0000, 32'h0,        32'h00003004, 4'b0000, 32'h0,        32'h0000F0AB, 1'b0, 5};
      vecs[4]  = '{OP_L, 3'b000, 32'h00005003, 32'h0,        32'h80000000, 32'h0,        1, 32'h00005000, 4'b0000, 32'h0,        32'h0,        4'b0000, 32'h0,        32'hFFFFFF80, 1'b0, 3};
      vecs[5]  = '{OP_L, 3'b010, 32'h00006000, 32'h0,        32'h89ABCDEF, 32'h0,        1, 32'h00006000, 4'b0000, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h89ABCDEF, 1'b0, 3};
      vecs[6]  = '{OP_S, 3'b001, 32'h00007002, 32'h0000BEEF, 32'h0,        32'h0,        1, 32'h00007000, 4'b1100, 32'hBEEF0000, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b0, 2};
      vecs[7]  = '{OP_L, 3'b100, 32'h00008001, 32'h0,        32'h12349A78, 32'h0,        1, 32'h00008000, 4'b0000, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0000009A, 1'b0, 3};
      vecs[8]  = '{OP_L, 3'b111, 32'h00009000, 32'h0,        32'h0,        32'h0,        0, 32'h0,        4'b0000, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0,        1'b1, 1};
      vecs[9]  = '{OP_S, 3'b100, 32'h00009004, 32'h00000055, 32'h0,        32'h0,        0, 32'h0,        4'b0000, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0,        1'b1, 1};
      vecs[10] = '{OP_L, 3'b011, 32'h00009008, 32'h0,        32'h0,        32'h0,        0, 32'h0,        4'b0000, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0,        1'b1, 1};
      vecs[11] = '{OP_N, 3'b000, 32'h0000900C, 32'h12345678, 32'h0,        32'h0,        0, 32'h0,        4'b0000, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0,        1'b0, 1};
      vecs[12] = '{OP_S, 3'b010, 32'hFFFFFFFE, 32'hAABBCCDD, 32'h0,        32'h0,        2, 32'hFFFFFFFC, 4'b1100, 32'hCCDD0000, 32'h00000000, 4'b0011, 32'h0000AABB, 32'h0,        1'b0, 3};
      vecs[13] = '{OP_L, 3'b010, 32'h00004001, 32'h0,        32'h44332211, 32'h88776655, 2, 32'h00004000, 4'b0000, 32'h0,        32'h00004004, 4'b0000, 32'h0,        32'h55443322, 1'b0, 5};
      vecs[14] = '{OP_L, 3'b001, 32'h00003002, 32'h0,        32'h80010000, 32'h0,        1, 32'h00003000, 4'b0000, 32'h0,        32'h0,        4'b0000, 32'h0,        32'hFFFF8001, 1'b0, 3};
      vecs[15] = '{OP_L, 3'b110, 32'h0000A000, 32'h0,        32'h0,        32'h0,        0, 32'h0,        4'b0000, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0,        1'b1, 1};

      // Reset values, sampled before any clock edge.
      #3;
      chk("rst_req_ready", 64'(req_ready), 64'(1));
      chk("rst_mem_valid", 64'(mem_valid), 64'(0));
      chk("rst_mem_we", 64'(mem_we), 64'(0));
      chk("rst_mem_addr", 64'(mem_addr), 64'(0));
      chk("rst_mem_wdata", 64'(mem_wdata), 64'(0));
      chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
      chk("rst_rsp_fault", 64'(rsp_fault), 64'(0));
      chk("rst_rsp_data", 64'(rsp_data), 64'(0));
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 16; i++) run_vec(vecs[i], i);

      // Misaligned word load on the non-splitting instance faults immediately.
      req_opcode = OP_L; req_funct3 = 3'b010; req_addr = 32'h00004001; req_wdata = '0;
      req_valid0 = 1'b1;
      @(posedge clk); #1;
      req_valid0 = 1'b0;
      @(negedge clk);
      chk("nosplit_mem_valid", 64'(mem_valid0), 64'(0));
      chk("nosplit_rsp_valid", 64'(rsp_valid0), 64'(1));
      chk("nosplit_rsp_fault", 64'(rsp_fault0), 64'(1));
      @(negedge clk);
      chk("nosplit_mem_valid_after", 64'(mem_valid0), 64'(0));
      chk("nosplit_rsp_one_cycle", 64'(rsp_valid0), 64'(0));

      // Bus backpressure: beat must hold steady while mem_ready is low.
      req_opcode = OP_S; req_funct3 = 3'b000; req_addr = 32'h00001003; req_wdata = 32'h000000A5;
      mem_ready = 1'b0;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk($sformatf("bp%0d_mem_valid", k), 64'(mem_valid), 64'(1));
         chk($sformatf("bp%0d_mem_addr", k), 64'(mem_addr), 64'h1000);
         chk($sformatf("bp%0d_mem_we", k), 64'(mem_we), 64'(4'b1000));
         chk($sformatf("bp%0d_mem_wdata", k), 64'(mem_wdata), 64'hA5000000);
         chk($sformatf("bp%0d_req_ready", k), 64'(req_ready), 64'(0));
      end
      mem_ready = 1'b1;
      @(negedge clk);
      chk("bp_rsp_valid", 64'(rsp_valid), 64'(1));
      chk("bp_rsp_fault", 64'(rsp_fault), 64'(0));
      @(negedge clk);
      chk("bp_idle_ready", 64'(req_ready), 64'(1));

      // Reset in WAIT0 abandons the load; a late read return is ignored.
      req_opcode = OP_L; req_funct3 = 3'b010; req_addr = 32'h00006000; req_wdata = '0;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("midrst_mem_valid", 64'(mem_valid), 64'(0));
      chk("midrst_rsp_valid", 64'(rsp_valid), 64'(0));
      chk("midrst_req_ready", 64'(req_ready), 64'(1));
      chk("midrst_mem_addr", 64'(mem_addr), 64'(0));
      chk("midrst_rsp_data", 64'(rsp_data), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h13579BDF;
      @(posedge clk); #1;
      mem_rvalid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk($sformatf("late_rvalid%0d_rsp_valid", k), 64'(rsp_valid), 64'(0));
         chk($sformatf("late_rvalid%0d_req_ready", k), 64'(req_ready), 64'(1));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_stage_lsu.md
MEM_STAGE_LSU -- requirements
Module: mem_stage_lsu

Interface
REQ-001 SHALL provide parameter XLEN, default 32, meaning datapath width (32 or 64); NB = XLEN/8 bytes per word.
REQ-002 SHALL provide parameter SPLIT_MISALIGNED, default 1, meaning 1 = split word-crossing accesses into two beats, 0 = fault every misaligned access.
REQ-003 SHALL have clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have req_valid  input  1 and req_ready  output  1: pipeline request handshake.
REQ-006 SHALL have req_opcode  input  7, req_funct3  input  3, req_addr  input  XLEN (ALU result), req_wdata  input  XLEN (rs2).
REQ-007 SHALL have mem_valid  output  1, mem_ready  input  1, mem_addr  output  XLEN (NB-aligned), mem_we  output  NB (byte enables, all 0 = read), mem_wdata  output  XLEN.
REQ-008 SHALL have mem_rvalid  input  1, mem_rdata  input  XLEN: read return, at least one cycle after read accept.
REQ-009 SHALL have rsp_valid  output  1, rsp_data  output  XLEN, rsp_fault  output  1.

Function
REQ-010 SHALL implement states IDLE, ISSUE0, WAIT0, ISSUE1, WAIT1, RESP; req_ready = 1 only in IDLE; one request outstanding.
REQ-011 SHALL, in IDLE on req_valid, latch opcode, funct3, addr, wdata; offset = addr mod NB; size from funct3[1:0] (B=1, H=2, W=4, D=8).
REQ-012 SHALL treat as invalid, going IDLE->RESP with rsp_fault=1 and no bus beat: load funct3 111; store funct3[2]=1; funct3 011/110 when XLEN=32.
REQ-013 SHALL treat opcode other than load 0000011 / store 0100011 as no-op: IDLE->RESP, rsp_fault=0, rsp_data=0, no bus beat.
REQ-014 SHALL, for misaligned (addr mod size != 0) with SPLIT_MISALIGNED=0, go IDLE->RESP with rsp_fault=1, no bus beat.
REQ-015 SHALL otherwise go IDLE->ISSUE0; cross = (offset + size > NB).
REQ-016 SHALL form 2*NB-bit mask = ((1<<size)-1) << offset and 2*XLEN-bit data = wdata << (8*offset); beat0 uses low halves, beat1 high halves; mem_we = 0 for loads.
REQ-017 SHALL drive mem_valid=1 in ISSUE0/ISSUE1 with mem_addr = addr & ~(NB-1) (ISSUE0) or that + NB (ISSUE1, wraps modulo 2^XLEN); addr/we/wdata stable until mem_ready.
REQ-018 SHALL transition on mem_ready: ISSUE0 -> WAIT0 (load), ISSUE1 (store, cross), RESP (store, no cross); ISSUE1 -> WAIT1 (load), RESP (store).
REQ-019 SHALL capture mem_rdata on mem_rvalid: WAIT0 -> ISSUE1 if cross else RESP; WAIT1 -> RESP; mem_rvalid ignored in other states.
REQ-020 SHALL form load result as {hi,lo} >> (8*offset), low size bytes, sign-extended for LB/LH/LW, zero-extended for LBU/LHU/LWU/LD.
REQ-021 SHALL assert rsp_valid for exactly one cycle in RESP, then return to IDLE; no response backpressure.
REQ-022 SHALL give min latency (mem_ready=1, rvalid next cycle): aligned store 2 cycles accept->rsp_valid, aligned load 3, split store 3, split load 5, fault/no-op 1.
REQ-023 SHALL hold rsp_data and rsp_fault at last values outside RESP; stores return rsp_data=0.

Reset
REQ-024 SHALL, on rst_n low, immediately force state IDLE, mem_valid=0, mem_we=0, mem_addr=0, mem_wdata=0, rsp_valid=0, rsp_fault=0, rsp_data=0, req_ready=1.
REQ-025 SHALL abandon any in-flight access on mid-operation reset; a late mem_rvalid after release is ignored in IDLE.

Verification
REQ-026 SB addr 0x1003 wdata 0x000000A5, mem_ready=1 -> one beat addr 0x1000, we 1000, wdata 0xA5000000; rsp_valid 2 cycles after accept.
REQ-027 SW addr 0x2002 wdata 0x11223344, SPLIT=1 -> beat0 0x2000 we 1100 wdata 0x33440000; beat1 0x2004 we 0011 wdata 0x00001122.
REQ-028 LH addr 0x3003, rdata 0xAB000000 then 0x000000F0 -> rsp_data 0xFFFFF0AB; LHU same -> 0x0000F0AB; LB 0x5003 rdata 0x80000000 -> 0xFFFFFF80.
REQ-029 SPLIT=0, LW addr 0x4001 -> mem_valid never 1; rsp_valid with rsp_fault=1 one cycle after accept.
REQ-030 mem_ready low 3 cycles in ISSUE0 -> mem_addr/we/wdata unchanged throughout, req_ready=0.
REQ-031 rst_n low during WAIT0 -> mem_valid, rsp_valid 0 at once; req_ready=1; late mem_rvalid yields no rsp_valid.
